// File: rtl/bus_burst_responder.sv
// Bus slave that answers single and burst reads/writes from a local word SRAM.
// Optional wait states are enabled by defining BUS_RESP_WAITSTATE_EN.
module bus_burst_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h5000_0000,
    parameter int unsigned WORD_ADDR_BITS = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);
    localparam int unsigned DEPTH   = 1 << WORD_ADDR_BITS;
    localparam int unsigned TAG_LSB = WORD_ADDR_BITS + 2;
    localparam logic [31:0] MAX_IDX = 32'(DEPTH - 1);
`ifdef BUS_RESP_WAITSTATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD, RD_END, WR, WR_WAIT, ERR} state_e;

    state_e                    state_q;
    logic [31:0]               mem [DEPTH];
    logic [WORD_ADDR_BITS-1:0] idx_q;
    logic [7:0]                cnt_q;
    logic [3:0]                be_q;
    logic                      phase_q;
    logic [31:0]               rdata_q;
    logic                      rvalid_q;
    logic                      end_q;
    logic                      err_q;
    logic                      busy_q;

    logic [WORD_ADDR_BITS-1:0] begin_idx_c;
    logic [31:0]               last_idx_c;
    logic                      in_window_c;
    logic                      reject_c;
    logic                      wr_fire_c;

    // A burst must be word aligned and must not run past the last SRAM word.
    assign begin_idx_c = addressDataIn[TAG_LSB-1:2];
    assign in_window_c = addressDataIn[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
    assign last_idx_c  = 32'(begin_idx_c) + 32'(burstSizeIn);
    assign reject_c    = (addressDataIn[1:0] != 2'b00) || (last_idx_c > MAX_IDX);
    assign wr_fire_c   = (state_q == WR) && dataValidIn && !busy_q && !endTransactionIn;

    // SRAM has no reset so its contents survive a bus reset.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_fire_c && be_q[b]) begin
                mem[idx_q][8*b +: 8] <= addressDataIn[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            be_q     <= '0;
            phase_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (beginTransactionIn && in_window_c) begin
                        idx_q   <= begin_idx_c;
                        cnt_q   <= burstSizeIn;
                        be_q    <= byteEnablesIn;
                        phase_q <= 1'b0;
                        if (reject_c) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            end_q   <= 1'b1;
                        end else begin
                            state_q <= readNotWriteIn ? RD : WR;
                        end
                    end
                end
                ERR: state_q <= IDLE;
                RD: begin
                    if (endTransactionIn) begin
                        state_q <= IDLE;
                    end else if (WAIT_EN && !phase_q) begin
                        busy_q  <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        rdata_q  <= mem[idx_q];
                        rvalid_q <= 1'b1;
                        idx_q    <= idx_q + 1'b1;
                        phase_q  <= 1'b0;
                        if (cnt_q == 8'd0) begin
                            state_q <= RD_END;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                RD_END: begin
                    end_q   <= 1'b1;
                    state_q <= IDLE;
                end
                WR: begin
                    if (endTransactionIn) begin
                        state_q <= IDLE;
                    end else if (wr_fire_c) begin
                        idx_q  <= idx_q + 1'b1;
                        busy_q <= WAIT_EN;
                        if (cnt_q == 8'd0) begin
                            state_q <= WR_WAIT;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                WR_WAIT: begin
                    if (endTransactionIn) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addressDataOut    = rdata_q;
    assign dataValidOut      = rvalid_q;
    assign endTransactionOut = end_q;
    assign busErrorOut       = err_q;
    assign busyOut           = busy_q;
endmodule

// File: tb/tb_bus_burst_responder.sv
// Self-checking bench for bus_burst_responder: vector table, hand sequences and
// random transactions against a cycle-formula reference model (BUS_RESP_WAITSTATE_EN aware).
`timescale 1ns/1ps
module tb_bus_burst_responder;
    localparam int unsigned DEPTH = 512;
`ifdef BUS_RESP_WAITSTATE_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif
    localparam int KIND_IGN = 0;
    localparam int KIND_ERR = 1;
    localparam int KIND_OK  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        beginTransactionIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic        readNotWriteIn = 1'b0;
    logic [3:0]  byteEnablesIn = '0;
    logic [7:0]  burstSizeIn = '0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;
    logic        busyOut;

    bus_burst_responder dut (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
        .readNotWriteIn(readNotWriteIn), .byteEnablesIn(byteEnablesIn),
        .burstSizeIn(burstSizeIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .addressDataOut(addressDataOut),
        .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
        .busErrorOut(busErrorOut), .busyOut(busyOut)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        tend;
        logic        err;
        logic        busy;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        rnw;
        logic [7:0]  burst;
        logic [3:0]  be;
        int          abort;
        int          kind;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem_m [DEPTH];
    vec_t        vecs [12];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string name, input int t, input out_t exp);
        out_t act;
        act.data = addressDataOut; act.valid = dataValidOut; act.tend = endTransactionOut;
        act.err = busErrorOut; act.busy = busyOut;
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got data=%08h v=%b end=%b err=%b busy=%b required data=%08h v=%b end=%b err=%b busy=%b",
                     name, t, act.data, act.valid, act.tend, act.err, act.busy,
                     exp.data, exp.valid, exp.tend, exp.err, exp.busy);
        end
    endtask

    task automatic drive_idle();
        beginTransactionIn = 1'b0;
        dataValidIn = 1'b0;
        endTransactionIn = 1'b0;
    endtask

    function automatic int classify(input logic [31:0] a, input logic [7:0] b);
        if ((a >> 11) != (32'h5000_0000 >> 11)) return KIND_IGN;
        if (a[1:0] != 2'b00) return KIND_ERR;
        if (((a >> 2) & 32'h1FF) + 32'(b) > 32'd511) return KIND_ERR;
        return KIND_OK;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    // Expected read-side outputs t cycles after a begin at cycle 0.
    function automatic out_t exp_read(input int idx, input int b, input int t, input int abort);
        out_t e;
        e = '0;
        if (abort >= 1 && t > abort) return e;
        if (WAIT) begin
            if (t >= 2 && t <= 2*b+2 && t % 2 == 0) e.busy = 1'b1;
            if (t >= 3 && t <= 2*b+3 && t % 2 == 1) begin
                e.valid = 1'b1;
                e.data = mem_m[idx + (t-3)/2];
            end
            if (t == 2*b+4) e.tend = 1'b1;
        end else begin
            if (t >= 2 && t <= b+2) begin
                e.valid = 1'b1;
                e.data = mem_m[idx + t - 2];
            end
            if (t == b+3) e.tend = 1'b1;
        end
        return e;
    endfunction

    function automatic int last_rd_cycle(input int b);
        return WAIT ? 2*b+2 : b+1;
    endfunction

    // abort: read = cycle of endTransactionIn, write = beats accepted before it; -1 = none.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic rnw,
                           input logic [7:0] burst, input logic [3:0] be, input int abort,
                           input int kind, input bit seq, input bit noise);
        int idx, b, end_c, acc_n, extra, limit, t;
        bit done, busy_e, acc;
        logic [31:0] cur;
        out_t e;
        idx = int'((addr >> 2) & 32'h1FF);
        b = int'(burst);
        e = '0;
        check_out({name, ":idle"}, 0, e);
        beginTransactionIn = 1'b1; addressDataIn = addr; readNotWriteIn = rnw;
        byteEnablesIn = be; burstSizeIn = burst; dataValidIn = 1'b0; endTransactionIn = 1'b0;
        step();
        beginTransactionIn = 1'b0;
        readNotWriteIn = 1'($urandom); byteEnablesIn = 4'($urandom);
        burstSizeIn = 8'($urandom); addressDataIn = $urandom;
        if (kind != KIND_OK) begin
            for (t = 1; t <= 3; t++) begin
                e = '0;
                if (kind == KIND_ERR && t == 1) begin e.err = 1'b1; e.tend = 1'b1; end
                check_out(name, t, e);
                step();
            end
        end else if (rnw) begin
            end_c = WAIT ? 2*b+4 : b+3;
            for (t = 1; t <= end_c + 1; t++) begin
                check_out(name, t, exp_read(idx, b, t, abort));
                endTransactionIn = (t == abort);
                beginTransactionIn = noise && (t <= ((abort >= 1) ? abort : end_c - 1))
                                     && ($urandom % 4 == 0);
                if (beginTransactionIn) addressDataIn = 32'h5000_0000 | ($urandom & 32'h7FC);
                step();
            end
            drive_idle();
        end else begin
            acc_n = 0; busy_e = 1'b0; done = 1'b0; extra = 0; t = 1;
            limit = 6*(b+1) + 20;
            cur = seq ? 32'd1 : $urandom;
            while (!done && t < limit) begin
                e = '0; e.busy = busy_e;
                check_out(name, t, e);
                drive_idle();
                if (acc_n == b + 1) begin
                    if (extra < 2) begin
                        dataValidIn = 1'b1; addressDataIn = $urandom; extra++;
                    end else begin
                        endTransactionIn = 1'b1; done = 1'b1;
                    end
                end else if (abort >= 0 && acc_n == abort) begin
                    endTransactionIn = 1'b1; done = 1'b1;
                end else begin
                    dataValidIn = ($urandom % 4 != 0);
                    addressDataIn = cur;
                end
                if (noise && $urandom % 8 == 0) beginTransactionIn = 1'b1;
                acc = dataValidIn && !busy_e && (acc_n < b + 1) && !endTransactionIn;
                if (acc) begin
                    model_write(idx + acc_n, cur, be);
                    acc_n++;
                    cur = seq ? 32'(acc_n + 1) : $urandom;
                end
                step();
                busy_e = WAIT && acc;
                t++;
            end
            if (!done) begin
                checks++; failures++;
                $display("FAIL %s timeout: accepted=%0d beats, required=%0d", name, acc_n, b + 1);
            end
            drive_idle();
            e = '0;
            check_out({name, ":after"}, t, e);
            step();
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [7:0]  burst;
        logic        rnw;
        int          kind, abort, r, tb_beat;
        out_t        z;
        z = '0;

        vecs[0]  = '{"wr_t1",        32'h5000_0010, 1'b0, 8'd3,   4'hF, -1, KIND_OK};
        vecs[1]  = '{"rd_t2",        32'h5000_0010, 1'b1, 8'd3,   4'h0, -1, KIND_OK};
        vecs[2]  = '{"rd_511_b1",    32'h5000_07FC, 1'b1, 8'd1,   4'hF, -1, KIND_ERR};
        vecs[3]  = '{"out_window",   32'h4000_0000, 1'b1, 8'd0,   4'hF, -1, KIND_IGN};
        vecs[4]  = '{"misalign",     32'h5000_0002, 1'b1, 8'd0,   4'hF, -1, KIND_ERR};
        vecs[5]  = '{"rd_511_b0",    32'h5000_07FC, 1'b1, 8'd0,   4'h0, -1, KIND_OK};
        vecs[6]  = '{"wr_be3_abort", 32'h5000_0100, 1'b0, 8'd7,   4'h3, 2,  KIND_OK};
        vecs[7]  = '{"rd_aborted",   32'h5000_0100, 1'b1, 8'd7,   4'h0, -1, KIND_OK};
        vecs[8]  = '{"wr_overflow",  32'h5000_0404, 1'b0, 8'd255, 4'hF, -1, KIND_ERR};
        vecs[9]  = '{"above_window", 32'h5000_0800, 1'b0, 8'd0,   4'hF, -1, KIND_IGN};
        vecs[10] = '{"wr_abort0",    32'h5000_0020, 1'b0, 8'd2,   4'hF, 0,  KIND_OK};
        vecs[11] = '{"rd_abort3",    32'h5000_0000, 1'b1, 8'd5,   4'h0, 3,  KIND_OK};

        step();
        check_out("reset_state", 0, z);
        step();
        reset = 1'b0;
        step();

        // Fill the whole SRAM so every later read has a known model value.
        run_txn("fill_lo", 32'h5000_0000, 1'b0, 8'd255, 4'hF, -1, KIND_OK, 1'b0, 1'b0);
        run_txn("fill_hi", 32'h5000_0400, 1'b0, 8'd255, 4'hF, -1, KIND_OK, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].name, vecs[i].addr, vecs[i].rnw, vecs[i].burst, vecs[i].be,
                    vecs[i].abort, vecs[i].kind, 1'b1, 1'b0);
        end
        run_txn("rd_4_to_8", 32'h5000_0010, 1'b1, 8'd4, 4'h0, -1, KIND_OK, 1'b0, 1'b0);

        // Asynchronous reset in the middle of beat 2 of a read.
        tb_beat = WAIT ? 5 : 3;
        beginTransactionIn = 1'b1; addressDataIn = 32'h5000_0010; readNotWriteIn = 1'b1;
        burstSizeIn = 8'd3;
        step();
        beginTransactionIn = 1'b0;
        for (int t = 1; t <= tb_beat; t++) begin
            check_out("rst_pre", t, exp_read(4, 3, t, -1));
            if (t < tb_beat) step();
        end
        #2 reset = 1'b1;
        #1 check_out("rst_async", tb_beat, z);
        step();
        check_out("rst_held", tb_beat + 1, z);
        reset = 1'b0;
        step();
        run_txn("rd_after_rst", 32'h5000_0010, 1'b1, 8'd3, 4'h0, -1, KIND_OK, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom % 10);
            burst = 8'($urandom % 16);
            if (r == 0) begin
                addr = $urandom;
                if (classify(addr, burst) != KIND_IGN) addr[31] = ~addr[31];
            end else if (r == 1) begin
                addr = 32'h5000_0000 | ($urandom & 32'h7FC) | 32'(1 + $urandom % 3);
            end else if (r == 2) begin
                addr = 32'h5000_0000 | (32'(511 - $urandom % 16) << 2);
            end else begin
                addr = 32'h5000_0000 | ($urandom & 32'h7FC);
            end
            rnw = 1'($urandom);
            kind = classify(addr, burst);
            abort = -1;
            if ($urandom % 4 == 0) begin
                if (rnw) abort = 1 + int'($urandom % 32'(last_rd_cycle(int'(burst))));
                else     abort = int'($urandom % (32'(burst) + 1));
            end
            run_txn("random", addr, rnw, burst, 4'($urandom), abort, kind, 1'b0, 1'b1);
            repeat ($urandom % 3) begin
                check_out("idle_noise", 0, z);
                dataValidIn = 1'($urandom);
                endTransactionIn = 1'($urandom);
                step();
            end
            drive_idle();
        end

        run_txn("readback_lo", 32'h5000_0000, 1'b1, 8'd255, 4'h0, -1, KIND_OK, 1'b0, 1'b0);
        run_txn("readback_hi", 32'h5000_0400, 1'b1, 8'd255, 4'h0, -1, KIND_OK, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
